// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Provides the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The bit counter must be at least one bit wide, even when WIDTH is 1.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Handshake and data bundle of the serial adder.
// The slave side is the adder; the master side issues operands and consumes results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start_valid, a, b, cin, sub, done_ready,
    input  start_ready, sum, cout, overflow, done_valid
  );

  modport slave (
    input  start_valid, a, b, cin, sub, done_ready,
    output start_ready, sum, cout, overflow, done_valid
  );

endinterface

// File: rtl/serial_adder_bit_adder_cell.sv
// Combinational one-bit full adder.
// Time-multiplexed by serial_adder over all operand bits.
module bit_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB first
// over WIDTH cycles, with valid/ready handshakes on the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic             bit_s;
  logic             co_s;
  logic             last_s;
  logic [WIDTH:0]   res_ext_s;

  bit_adder_cell u_cell (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (bit_s),
    .co (co_s)
  );

  // New bit enters at the MSB; slicing the extended vector also works for WIDTH=1.
  assign res_ext_s = {bit_s, res_q};
  assign last_s    = (count_q == CW'(WIDTH - 1));

  // Next-state, datapath shift and result-capture logic.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          // Subtract is a + ~b + 1, so the carry flop starts as cin^sub.
          opa_d   = bus.a;
          opb_d   = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.cin ^ bus.sub;
          res_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        opa_d   = opa_q >> 1'b1;
        opb_d   = opb_q >> 1'b1;
        carry_d = co_s;
        res_d   = res_ext_s[WIDTH:1];
        count_d = count_q + CW'(1);
        if (last_s) begin
          // carry_q here is the carry into the MSB, needed for signed overflow.
          sum_d   = res_ext_s[WIDTH:1];
          cout_d  = co_s;
          ovf_d   = carry_q ^ co_s;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.done_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.done_valid  = (state_q == DONE);
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8, plus exhaustive
// WIDTH=1 and WIDTH=3 instances checked against an arithmetic reference.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_if #(.WIDTH(8)) v8 ();
  serial_adder_if #(.WIDTH(1)) v1 ();
  serial_adder_if #(.WIDTH(3)) v3 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(v8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(v1));
  serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(v3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs one WIDTH=8 operation and returns the result and the accept-to-done latency.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic is, output logic [7:0] os, output logic oc,
                      output logic oo, output int lat);
    @(negedge clk);
    v8.a = ia; v8.b = ib; v8.cin = ic; v8.sub = is; v8.start_valid = 1'b1;
    @(posedge clk); #1;
    v8.start_valid = 1'b0;
    lat = 0;
    while (!v8.done_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    os = v8.sum; oc = v8.cout; oo = v8.overflow;
    @(negedge clk);
    v8.done_ready = 1'b1;
    @(posedge clk); #1;
    v8.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (v8.done_valid !== 1'b0 || v8.start_ready !== 1'b1 || v8.sum !== 8'h00 ||
        v8.cout !== 1'b0 || v8.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: dv=%b sr=%b sum=%h cout=%b ovf=%b, want dv=0 sr=1 sum=00 cout=0 ovf=0",
               v8.done_valid, v8.start_ready, v8.sum, v8.cout, v8.overflow);
    end
  endtask

  task automatic test_basic_add();
    logic [7:0] s; logic c, o; int lat;
    run8(8'h0F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if ({s, c, o} !== {8'h10, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_add: sum=%h cout=%b ovf=%b want 10 0 0", s, c, o);
    end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    @(negedge clk);
    v8.a = 8'hAA; v8.b = 8'h11; v8.cin = 1'b0; v8.sub = 1'b0; v8.start_valid = 1'b1;
    @(posedge clk); #1;
    v8.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (v8.done_valid !== 1'b0 || v8.start_ready !== 1'b1 || v8.sum !== 8'h00 ||
        v8.cout !== 1'b0 || v8.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy: dv=%b sr=%b sum=%h cout=%b ovf=%b, want 0 1 00 0 0",
               v8.done_valid, v8.start_ready, v8.sum, v8.cout, v8.overflow);
    end
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (v8.done_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_no_done: done_valid seen %0d cycles, want 0", seen); end
  endtask

  task automatic test_carry_overflow();
    logic [7:0] s; logic c, o; int lat;
    run8(8'hFF, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_ff_01: sum=%h cout=%b ovf=%b want 00 1 0", s, c, o);
    end
    run8(8'h7F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h80, 1'b0, 1'b1}) begin
      failures++; $display("FAIL add_7f_01: sum=%h cout=%b ovf=%b want 80 0 1", s, c, o);
    end
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'hFF, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_ff_ff_c1: sum=%h cout=%b ovf=%b want ff 1 0", s, c, o);
    end
  endtask

  task automatic test_subtract();
    logic [7:0] s; logic c, o; int lat;
    run8(8'h05, 8'h07, 1'b0, 1'b1, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'hFE, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_05_07: sum=%h cout=%b ovf=%b want fe 0 0", s, c, o);
    end
    run8(8'h80, 8'h01, 1'b0, 1'b1, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h7F, 1'b1, 1'b1}) begin
      failures++; $display("FAIL sub_80_01: sum=%h cout=%b ovf=%b want 7f 1 1", s, c, o);
    end
    run8(8'h05, 8'h02, 1'b1, 1'b1, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h02, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_05_02_b1: sum=%h cout=%b ovf=%b want 02 1 0", s, c, o);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    v8.a = 8'h33; v8.b = 8'h11; v8.cin = 1'b0; v8.sub = 1'b0; v8.start_valid = 1'b1;
    @(posedge clk); #1;
    v8.start_valid = 1'b0;
    lat = 0;
    while (!v8.done_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL bp_first_latency: got %0d want 8", lat); end
    @(negedge clk);
    v8.a = 8'h20; v8.b = 8'h03; v8.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (v8.done_valid !== 1'b1 || v8.start_ready !== 1'b0 || v8.sum !== 8'h44 ||
          v8.cout !== 1'b0 || v8.overflow !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: dv=%b sr=%b sum=%h cout=%b ovf=%b want 1 0 44 0 0",
                 i, v8.done_valid, v8.start_ready, v8.sum, v8.cout, v8.overflow);
      end
    end
    @(negedge clk);
    v8.done_ready = 1'b1;
    @(posedge clk); #1;
    v8.done_ready = 1'b0;
    checks++;
    if (v8.start_ready !== 1'b1 || v8.done_valid !== 1'b0 || v8.sum !== 8'h44) begin
      failures++;
      $display("FAIL bp_idle_gap: sr=%b dv=%b sum=%h want 1 0 44", v8.start_ready, v8.done_valid, v8.sum);
    end
    @(posedge clk); #1;
    v8.start_valid = 1'b0;
    checks++;
    if (v8.start_ready !== 1'b0) begin failures++; $display("FAIL bp_accept: sr=%b want 0", v8.start_ready); end
    lat = 0;
    while (!v8.done_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 8 || v8.sum !== 8'h23 || v8.cout !== 1'b0) begin
      failures++; $display("FAIL bp_second: lat=%0d sum=%h cout=%b want 8 23 0", lat, v8.sum, v8.cout);
    end
    @(negedge clk);
    v8.done_ready = 1'b1;
    @(posedge clk); #1;
    v8.done_ready = 1'b0;
  endtask

  task automatic test_exhaustive_w1();
    int lat, full, bad;
    logic bop, es, ec, eo;
    bad = 0;
    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            bop  = is[0] ? ~ib[0] : ib[0];
            full = ia + int'(bop) + (ic ^ is);
            es   = full[0];
            ec   = full[1];
            eo   = (ia[0] == bop) && (es != ia[0]);
            @(negedge clk);
            v1.a = ia[0]; v1.b = ib[0]; v1.cin = ic[0]; v1.sub = is[0]; v1.start_valid = 1'b1;
            @(posedge clk); #1;
            v1.start_valid = 1'b0;
            lat = 0;
            while (!v1.done_valid && lat < 40) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat !== 1 || v1.sum !== es || v1.cout !== ec || v1.overflow !== eo) begin
              failures++; bad++;
              $display("FAIL w1 a=%0d b=%0d cin=%0d sub=%0d: lat=%0d sum=%b cout=%b ovf=%b want 1 %b %b %b",
                       ia, ib, ic, is, lat, v1.sum, v1.cout, v1.overflow, es, ec, eo);
            end
            @(negedge clk);
            v1.done_ready = 1'b1;
            @(posedge clk); #1;
            v1.done_ready = 1'b0;
          end
  endtask

  task automatic test_exhaustive_w3();
    int lat, full;
    logic [2:0] bop, es;
    logic ec, eo;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            bop  = is[0] ? ~3'(ib) : 3'(ib);
            full = ia + int'(bop) + (ic ^ is);
            es   = full[2:0];
            ec   = full[3];
            eo   = (ia[2] == bop[2]) && (es[2] != ia[2]);
            @(negedge clk);
            v3.a = 3'(ia); v3.b = 3'(ib); v3.cin = ic[0]; v3.sub = is[0]; v3.start_valid = 1'b1;
            @(posedge clk); #1;
            v3.start_valid = 1'b0;
            lat = 0;
            while (!v3.done_valid && lat < 40) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat !== 3 || v3.sum !== es || v3.cout !== ec || v3.overflow !== eo) begin
              failures++;
              $display("FAIL w3 a=%0d b=%0d cin=%0d sub=%0d: lat=%0d sum=%0d cout=%b ovf=%b want 3 %0d %b %b",
                       ia, ib, ic, is, lat, v3.sum, v3.cout, v3.overflow, es, ec, eo);
            end
            @(negedge clk);
            v3.done_ready = 1'b1;
            @(posedge clk); #1;
            v3.done_ready = 1'b0;
          end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    v8.start_valid = 1'b0; v8.a = 8'h00; v8.b = 8'h00; v8.cin = 1'b0; v8.sub = 1'b0; v8.done_ready = 1'b0;
    v1.start_valid = 1'b0; v1.a = 1'b0;  v1.b = 1'b0;  v1.cin = 1'b0; v1.sub = 1'b0; v1.done_ready = 1'b0;
    v3.start_valid = 1'b0; v3.a = 3'd0;  v3.b = 3'd0;  v3.cin = 1'b0; v3.sub = 1'b0; v3.done_ready = 1'b0;
    #2;
    test_reset();
    #10 rst_n = 1'b1;
    test_basic_add();
    test_reset_mid_busy();
    test_carry_overflow();
    test_subtract();
    test_backpressure();
    test_exhaustive_w1();
    test_exhaustive_w3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
